// File: rtl/ext_interrupt_controller_pkg.sv
// ExtInterruptTypes: sizing constants, path typedefs and config word map for ext_interrupt_controller.
package ExtInterruptTypes;
    localparam int NUM_SOURCES    = 8;
    localparam int PRIORITY_WIDTH = 3;
    localparam int CODE_WIDTH     = $clog2(NUM_SOURCES + 1);
    localparam int CFG_ADDR_WIDTH = 6;

    typedef logic [CODE_WIDTH-1:0]     ExtIntIdPath;
    typedef logic [PRIORITY_WIDTH-1:0] ExtIntPriorityPath;
    typedef ExtIntIdPath               ExternalInterruptCodePath;
    typedef logic [CFG_ADDR_WIDTH-1:0] ExtIntCfgAddrPath;

    localparam ExtIntCfgAddrPath CFG_ENABLE        = ExtIntCfgAddrPath'(0);
    localparam ExtIntCfgAddrPath CFG_EDGE_MODE     = ExtIntCfgAddrPath'(1);
    localparam ExtIntCfgAddrPath CFG_THRESHOLD     = ExtIntCfgAddrPath'(2);
    localparam ExtIntCfgAddrPath CFG_PENDING       = ExtIntCfgAddrPath'(3);
    localparam ExtIntCfgAddrPath CFG_INFLIGHT      = ExtIntCfgAddrPath'(4);
    localparam ExtIntCfgAddrPath CFG_PRIORITY_BASE = ExtIntCfgAddrPath'(8);
endpackage

// File: rtl/ext_interrupt_controller_if.sv
// ext_interrupt_controller_if: device lines, config bus, CSR request and claim/complete handshake.
interface ext_interrupt_controller_if;
    import ExtInterruptTypes::*;

    logic [NUM_SOURCES-1:0]   srcIrq;
    logic                     cfgWE;
    ExtIntCfgAddrPath         cfgAddr;
    logic [31:0]              cfgWData;
    logic [31:0]              cfgRData;
    logic                     reqExternalInterrupt;
    ExternalInterruptCodePath externalInterruptCode;
    logic                     claimReq;
    ExtIntIdPath              claimId;
    logic                     completeReq;
    ExtIntIdPath              completeId;

    modport master (
        output srcIrq, cfgWE, cfgAddr, cfgWData, claimReq, completeReq, completeId,
        input  cfgRData, reqExternalInterrupt, externalInterruptCode, claimId
    );
    modport slave (
        input  srcIrq, cfgWE, cfgAddr, cfgWData, claimReq, completeReq, completeId,
        output cfgRData, reqExternalInterrupt, externalInterruptCode, claimId
    );
endinterface

// File: rtl/ext_interrupt_gateway.sv
// ext_interrupt_gateway: per-source level/edge gateway holding pending and in-flight state.
// RSD_EXT_INT_SRC_SYNC_EN inserts a 2-flop synchroniser ahead of the gateway.
module ext_interrupt_gateway
    import ExtInterruptTypes::*;
(
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    input  logic edge_mode_i,
    input  logic claim_hit_i,
    input  logic complete_hit_i,
    output logic pending_o,
    output logic in_flight_o
);
    logic irq, trig, in_flight_kept;
    logic prev_irq_q, pending_q, pending_d, in_flight_q, in_flight_d;

`ifdef RSD_EXT_INT_SRC_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[0], irq_i};
    end
    assign irq = sync_q[1];
`else
    assign irq = irq_i;
`endif

    // Completion is applied first so a re-asserted level line can go pending on the same edge.
    always_comb begin
        in_flight_kept = in_flight_q && !complete_hit_i;
        trig           = edge_mode_i ? (irq && !prev_irq_q) : irq;
        pending_d      = (pending_q && !claim_hit_i) || (trig && !pending_q && !in_flight_kept);
        in_flight_d    = in_flight_kept || claim_hit_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_irq_q  <= 1'b0;
            pending_q   <= 1'b0;
            in_flight_q <= 1'b0;
        end else begin
            prev_irq_q  <= irq;
            pending_q   <= pending_d;
            in_flight_q <= in_flight_d;
        end
    end

    assign pending_o   = pending_q;
    assign in_flight_o = in_flight_q;
endmodule

// File: rtl/ext_interrupt_controller.sv
// ext_interrupt_controller: enable/priority/threshold arbitration of external sources with claim/complete.
// RSD_EXT_INT_SRC_SYNC_EN (in ext_interrupt_gateway) adds source synchronisers, raising latency to 4 cycles.
module ext_interrupt_controller
    import ExtInterruptTypes::*;
(
    input logic clk,
    input logic rst,
    ext_interrupt_controller_if.slave bus
);
    logic [NUM_SOURCES-1:0] enable_q, enable_d, edge_mode_q, edge_mode_d;
    logic [NUM_SOURCES-1:0] pending, in_flight, claim_hit, complete_hit;
    ExtIntPriorityPath      threshold_q, threshold_d, best_prio;
    ExtIntPriorityPath      prio_q [NUM_SOURCES];
    ExtIntPriorityPath      prio_d [NUM_SOURCES];
    ExtIntIdPath            best_id, code_q, claim_id_q;
    logic                   req_q;
    logic [31:0]            rdata;
    logic                   cfg_unused;

    assign cfg_unused = ^bus.cfgWData[31:NUM_SOURCES];

    always_comb begin
        enable_d    = (bus.cfgWE && bus.cfgAddr == CFG_ENABLE) ? bus.cfgWData[NUM_SOURCES-1:0] : enable_q;
        edge_mode_d = (bus.cfgWE && bus.cfgAddr == CFG_EDGE_MODE) ? bus.cfgWData[NUM_SOURCES-1:0] : edge_mode_q;
        threshold_d = (bus.cfgWE && bus.cfgAddr == CFG_THRESHOLD) ? bus.cfgWData[PRIORITY_WIDTH-1:0] : threshold_q;
        for (int i = 0; i < NUM_SOURCES; i++)
            prio_d[i] = (bus.cfgWE && bus.cfgAddr == CFG_PRIORITY_BASE + ExtIntCfgAddrPath'(i))
                        ? bus.cfgWData[PRIORITY_WIDTH-1:0] : prio_q[i];
    end

    // Strict '>' keeps the earlier (lower) ID on equal priority.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 0; i < NUM_SOURCES; i++)
            if (pending[i] && enable_q[i] && prio_q[i] > threshold_q && prio_q[i] > best_prio) begin
                best_id   = ExtIntIdPath'(i + 1);
                best_prio = prio_q[i];
            end
    end

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : gw
        assign claim_hit[g]    = bus.claimReq && best_id == ExtIntIdPath'(g + 1);
        assign complete_hit[g] = bus.completeReq && bus.completeId == ExtIntIdPath'(g + 1);
        ext_interrupt_gateway u_gateway (
            .clk            (clk),
            .rst            (rst),
            .irq_i          (bus.srcIrq[g]),
            .edge_mode_i    (edge_mode_q[g]),
            .claim_hit_i    (claim_hit[g]),
            .complete_hit_i (complete_hit[g]),
            .pending_o      (pending[g]),
            .in_flight_o    (in_flight[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q    <= '0;
            edge_mode_q <= '0;
            threshold_q <= '0;
            prio_q      <= '{default: '0};
            code_q      <= '0;
            req_q       <= 1'b0;
            claim_id_q  <= '0;
        end else begin
            enable_q    <= enable_d;
            edge_mode_q <= edge_mode_d;
            threshold_q <= threshold_d;
            prio_q      <= prio_d;
            code_q      <= best_id;
            req_q       <= best_id != '0;
            if (bus.claimReq) claim_id_q <= best_id;
        end
    end

    always_comb begin
        rdata = bus.cfgAddr == CFG_ENABLE    ? 32'(enable_q)    :
                bus.cfgAddr == CFG_EDGE_MODE ? 32'(edge_mode_q) :
                bus.cfgAddr == CFG_THRESHOLD ? 32'(threshold_q) :
                bus.cfgAddr == CFG_PENDING   ? 32'(pending)     :
                bus.cfgAddr == CFG_INFLIGHT  ? 32'(in_flight)   : '0;
        for (int i = 0; i < NUM_SOURCES; i++)
            if (bus.cfgAddr == CFG_PRIORITY_BASE + ExtIntCfgAddrPath'(i)) rdata = 32'(prio_q[i]);
    end

    assign bus.cfgRData              = rdata;
    assign bus.reqExternalInterrupt  = req_q;
    assign bus.externalInterruptCode = code_q;
    assign bus.claimId               = claim_id_q;
endmodule
